// File: rtl/round_key_sequencer_if.sv
// Bundle between the round-key sequencer and its surroundings: start/config in,
// round keys out under a valid/ready handshake.
//
// Handshake: round_key, round_idx and last are meaningful only while key_valid=1
// and hold stable until a rising edge sees key_valid=1 and key_ready=1 (a
// transfer); key_valid never depends combinationally on key_ready.
interface round_key_sequencer_if #(
  parameter int MAX_ROUNDS = 14,
  parameter int KW         = 128
);
  logic                         start;
  logic [1:0]                   key_size;
  logic                         decrypt;
  logic [(MAX_ROUNDS+1)*KW-1:0] key_exp;
  logic                         key_ready;
  logic                         abort;
  logic [KW-1:0]                round_key;
  logic                         key_valid;
  logic [3:0]                   round_idx;
  logic                         last;
  logic                         busy;
  logic                         done;
  logic                         err;

  modport master (
    input  start, key_size, decrypt, key_exp, key_ready, abort,
    output round_key, key_valid, round_idx, last, busy, done, err
  );

  modport slave (
    output start, key_size, decrypt, key_exp, key_ready, abort,
    input  round_key, key_valid, round_idx, last, busy, done, err
  );
endinterface

// File: rtl/round_key_sequencer.sv
// Presents AES round keys from a flat expanded-key bus one per transfer,
// ascending for encryption and descending for decryption.
module round_key_sequencer #(
  parameter int MAX_ROUNDS = 14,
  parameter int KW         = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  round_key_sequencer_if.master  bus,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_n;
  logic [3:0]    idx_q, idx_n;
  logic [3:0]    nr_q, nr_n, nr_sel;
  logic          dec_q, dec_n;
  logic          err_q, err_n;
  logic          load, legal, last_now;
  logic [KW-1:0] key_q;
  logic [KW-1:0] keys [MAX_ROUNDS+1];

  // Key 0 sits at the most-significant end of key_exp.
  always_comb begin
    for (int i = 0; i <= MAX_ROUNDS; i++) begin
      keys[i] = bus.key_exp[(MAX_ROUNDS - i) * KW +: KW];
    end
  end

  always_comb begin
    nr_sel = 4'd0;
    case (bus.key_size)
      2'd0:    nr_sel = 4'd10;
      2'd1:    nr_sel = 4'd12;
      2'd2:    nr_sel = 4'd14;
      default: nr_sel = 4'd0;
    endcase
    legal    = (bus.key_size != 2'd3) && (nr_sel <= 4'(MAX_ROUNDS));
    last_now = (state_q == ISSUE) && (dec_q ? (idx_q == 4'd0) : (idx_q == nr_q));

    state_n = state_q;
    idx_n   = idx_q;
    nr_n    = nr_q;
    dec_n   = dec_q;
    err_n   = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (legal) begin
            state_n = ISSUE;
            nr_n    = nr_sel;
            dec_n   = bus.decrypt;
            idx_n   = bus.decrypt ? nr_sel : 4'd0;
            load    = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ISSUE: begin
        // Abort wins over a transfer on the same edge.
        if (bus.abort) begin
          state_n = IDLE;
        end else if (bus.key_ready) begin
          if (last_now) begin
            state_n = DONE;
          end else begin
            idx_n = dec_q ? (idx_q - 4'd1) : (idx_q + 4'd1);
            load  = 1'b1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      nr_q    <= 4'd0;
      dec_q   <= 1'b0;
      err_q   <= 1'b0;
      key_q   <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      nr_q    <= nr_n;
      dec_q   <= dec_n;
      err_q   <= err_n;
      if (load) key_q <= keys[idx_n];
    end
  end

  assign bus.round_key = key_q;
  assign bus.round_idx = idx_q;
  assign bus.key_valid = (state_q == ISSUE);
  assign bus.busy      = (state_q == ISSUE);
  assign bus.last      = last_now;
  assign bus.done      = (state_q == DONE);
  assign bus.err       = err_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_round_key_sequencer.sv
// Bench for round_key_sequencer: expected index order per sequence is a queue
// built from Nr and direction; keys come from a bench-side table.
module tb_round_key_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] state_dbg, state_dbg10;
  int total = 0;
  int bad   = 0;
  logic [127:0] keys [15];

  round_key_sequencer_if #(.MAX_ROUNDS(14), .KW(128)) bus ();
  round_key_sequencer_if #(.MAX_ROUNDS(10), .KW(128)) bus10 ();

  round_key_sequencer #(.MAX_ROUNDS(14), .KW(128)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );
  round_key_sequencer #(.MAX_ROUNDS(10), .KW(128)) dut10 (
    .clk(clk), .rst(rst), .bus(bus10), .state_dbg(state_dbg10)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Key i is shifted in after key i-1, so key 0 ends up at the top.
  function automatic logic [15*128-1:0] pack15();
    logic [15*128-1:0] v = '0;
    for (int i = 0; i < 15; i++) v = (v << 128) | {{(14*128){1'b0}}, keys[i]};
    return v;
  endfunction

  function automatic logic [11*128-1:0] pack11();
    logic [11*128-1:0] v = '0;
    for (int i = 0; i < 11; i++) v = (v << 128) | {{(10*128){1'b0}}, keys[i]};
    return v;
  endfunction

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_key"},   bus.round_key, 128'd0);
    chk({tag, "_idx"},   bus.round_idx, 0);
    chk({tag, "_valid"}, bus.key_valid, 0);
    chk({tag, "_last"},  bus.last, 0);
    chk({tag, "_busy"},  bus.busy, 0);
    chk({tag, "_done"},  bus.done, 0);
    chk({tag, "_err"},   bus.err, 0);
  endtask

  // mode: 0 = ready held high, 1 = ready toggles 1,0,1,0, 2 = random ready
  task automatic run_seq(input int ks, input bit dec, input int mode,
                         input int abort_at, input int rst_at);
    int q[$];
    int nr, cyc;
    bit tog, rdy;
    nr = 10 + 2 * ks;
    q = {};
    for (int i = 0; i <= nr; i++) begin
      if (dec) q.push_front(i);
      else     q.push_back(i);
    end
    @(negedge clk);
    chk("idle_valid", bus.key_valid, 0);
    chk("idle_done",  bus.done, 0);
    bus.start    = 1'b1;
    bus.key_size = 2'(ks);
    bus.decrypt  = dec;
    bus.abort    = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    cyc = 0;
    tog = 1'b1;
    while (q.size() > 0 && cyc < 200) begin
      chk("valid", bus.key_valid, 1);
      chk("idx",   bus.round_idx, q[0]);
      chk("key",   bus.round_key, keys[q[0]]);
      chk("last",  bus.last, q.size() == 1);
      chk("busy",  bus.busy, 1);
      chk("err_busy",  bus.err, 0);
      chk("done_busy", bus.done, 0);
      if (q[0] == rst_at) begin
        #2 rst = 1'b1;
        #1 check_outputs_zero("rst_mid");
        @(posedge clk);
        #1 rst = 1'b0;
        bus.key_ready = 1'b0;
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       begin rdy = tog; tog = ~tog; end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.key_ready = rdy;
      bus.abort     = (q[0] == abort_at);
      // Start requests while busy must be ignored without err.
      bus.start     = ($urandom_range(0, 3) == 0);
      bus.key_size  = 2'($urandom_range(0, 3));
      bus.decrypt   = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      if (bus.abort) begin
        bus.abort     = 1'b0;
        bus.key_ready = 1'b0;
        chk("abort_valid", bus.key_valid, 0);
        chk("abort_last",  bus.last, 0);
        chk("abort_done",  bus.done, 0);
        @(negedge clk);
        chk("abort_done2",  bus.done, 0);
        chk("abort_valid2", bus.key_valid, 0);
        return;
      end
      if (rdy) void'(q.pop_front());
    end
    chk("timeout_left", q.size(), 0);
    bus.key_ready = 1'b0;
    chk("end_valid", bus.key_valid, 0);
    chk("end_done",  bus.done, 1);
    chk("end_last",  bus.last, 0);
    chk("end_busy",  bus.busy, 0);
    chk("end_err",   bus.err, 0);
    @(negedge clk);
    chk("post_done",  bus.done, 0);
    chk("post_valid", bus.key_valid, 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.key_size = 2'd0; bus.decrypt = 1'b0;
    bus.key_ready = 1'b0; bus.abort = 1'b0; bus.key_exp = '0;
    bus10.start = 1'b0; bus10.key_size = 2'd0; bus10.decrypt = 1'b0;
    bus10.key_ready = 1'b0; bus10.abort = 1'b0; bus10.key_exp = '0;

    // reset state
    #1 check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // AES-128 encrypt, patterned keys, ready held
    for (int i = 0; i < 15; i++) keys[i] = {16{8'(i)}};
    bus.key_exp = pack15();
    run_seq(0, 1'b0, 0, -1, -1);

    // AES-256 decrypt, random keys, ready toggling
    for (int i = 0; i < 15; i++) keys[i] = {$urandom, $urandom, $urandom, $urandom};
    bus.key_exp = pack15();
    run_seq(2, 1'b1, 1, -1, -1);

    // illegal key_size rejected
    @(negedge clk);
    bus.start = 1'b1; bus.key_size = 2'd3;
    @(negedge clk);
    bus.start = 1'b0;
    chk("err_pulse", bus.err, 1);
    chk("err_valid", bus.key_valid, 0);
    @(negedge clk);
    chk("err_clear", bus.err, 0);
    chk("err_valid2", bus.key_valid, 0);

    // AES-192 encrypt aborted at idx 5, then a fresh sequence
    run_seq(1, 1'b0, 0, 5, -1);
    run_seq(1, 1'b0, 2, -1, -1);

    // asynchronous reset at idx 7, then start right after release
    run_seq(0, 1'b0, 0, -1, 7);
    run_seq(0, 1'b1, 2, -1, -1);

    // smaller instance rejects key sizes above its round limit
    bus10.key_exp = pack11();
    for (int ks = 1; ks <= 3; ks++) begin
      @(negedge clk);
      bus10.start = 1'b1; bus10.key_size = 2'(ks);
      @(negedge clk);
      bus10.start = 1'b0;
      chk("err10_pulse", bus10.err, 1);
      chk("err10_valid", bus10.key_valid, 0);
      @(negedge clk);
      chk("err10_clear", bus10.err, 0);
    end
    @(negedge clk);
    bus10.start = 1'b1; bus10.key_size = 2'd0;
    @(negedge clk);
    bus10.start = 1'b0;
    chk("ok10_valid", bus10.key_valid, 1);
    chk("ok10_idx",   bus10.round_idx, 0);
    chk("ok10_key",   bus10.round_key, keys[0]);
    chk("ok10_err",   bus10.err, 0);
    bus10.abort = 1'b1;
    @(negedge clk);
    bus10.abort = 1'b0;
    chk("ok10_abort_valid", bus10.key_valid, 0);
    chk("ok10_abort_done",  bus10.done, 0);

    // randomized sequences
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 15; i++) keys[i] = {$urandom, $urandom, $urandom, $urandom};
      bus.key_exp = pack15();
      run_seq(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 2,
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
